// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with ack timeout
//
// Ports:
//   clock       : single rising-edge clock
//   reset       : synchronous active-high reset
//   req         : request vector, bit i from requester i (2**N bits)
//   ack         : shared resource finished the granted transfer
//   grant       : one-hot grant, all zero when idle (registered)
//   grant_idx   : index of current or last grantee (registered)
//   busy        : high exactly when grant is non-zero (registered)
//   timeout_err : one-cycle pulse when a grant is revoked by timeout

module bus_arbiter_rr #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [(2**N)-1:0]   req,
  input  logic                ack,
  output logic [(2**N)-1:0]   grant,
  output logic [N-1:0]        grant_idx,
  output logic                busy,
  output logic                timeout_err
);

  localparam int         M    = 2**N;
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [N-1:0]   rr_ptr, rr_ptr_n;
  logic [N-1:0]   grant_idx_n;
  logic [7:0]     cnt, cnt_n;
  logic           timeout_err_n;
  logic [M-1:0]   grant_n;
  logic           busy_n;
  logic           found;
  logic [N-1:0]   sel;
  logic [N-1:0]   cand;

  // Cyclic priority search starting at rr_ptr; the N-bit add wraps
  // naturally from M-1 back to 0.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    cand  = rr_ptr;
    for (int i = 0; i < M; i++) begin
      cand = rr_ptr + N'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and next-output logic. Outputs are computed from the
  // next state so that every port comes straight from a flop.
  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    grant_idx_n   = grant_idx;
    cnt_n         = cnt;
    timeout_err_n = 1'b0;

    case (state)
      IDLE: begin
        // ack is deliberately ignored here
        if (found) begin
          state_n     = BUSY;
          grant_idx_n = sel;
          cnt_n       = 8'd0;
        end
      end
      BUSY: begin
        if (ack) begin
          // ack beats a simultaneous timeout
          state_n  = IDLE;
          rr_ptr_n = grant_idx + N'(1);
        end else if (cnt == TMAX) begin
          state_n       = IDLE;
          rr_ptr_n      = grant_idx + N'(1);
          timeout_err_n = 1'b1;
        end else if (cnt != 8'hFF) begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n  = (state_n == BUSY);
    grant_n = '0;
    if (busy_n) begin
      grant_n[grant_idx_n] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      cnt         <= 8'd0;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      grant_idx   <= grant_idx_n;
      cnt         <= cnt_n;
      grant       <= grant_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr

module tb_bus_arbiter_rr;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout_err;

  int total;
  int bad;

  bus_arbiter_rr #(.N(2), .TIMEOUT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic b, input logic te);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".idx"},   32'(grant_idx), 32'(idx));
    chk({tag, ".busy"},  32'(busy), 32'(b));
    chk({tag, ".terr"},  32'(timeout_err), 32'(te));
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    step(); step();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // ack ignored and nothing granted while idle without requests
    ack = 1'b1;
    step();
    chk_out("idle_ack", 4'b0000, 2'd0, 1'b0, 1'b0);
    ack = 1'b0;

    // basic grant to requester 2
    req = 4'b0100;
    step();
    chk_out("basic", 4'b0100, 2'd2, 1'b1, 1'b0);
    // grant held while req changes, including dropping req[2]
    req = 4'b0011;
    step();
    chk_out("hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    ack = 1'b1;
    step();
    chk_out("release", 4'b0000, 2'd2, 1'b0, 1'b0);
    ack = 1'b0;
    // rr_ptr is now 3: requester 3 wins over 0
    req = 4'b1001;
    step();
    chk_out("ptr3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    ack = 1'b1;
    step();
    chk_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b0);

    // round robin with all requesting, rr_ptr starts at 0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ack = 1'b0;
      step();
      chk($sformatf("rr%0d.grant", k), 32'(grant), 32'(rr_exp[k]));
      chk($sformatf("rr%0d.busy", k), 32'(busy), 32'd1);
      ack = 1'b1;
      step();
      chk($sformatf("rr%0d.gap", k), 32'(grant), 32'd0);
    end
    ack = 1'b0;
    req = 4'b0000;
    // rr_ptr now 1; grant requester 2 to move rr_ptr to 3
    req = 4'b0100;
    step();
    chk_out("to2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    ack = 1'b1;
    step();
    ack = 1'b0;
    // wrap search from rr_ptr 3
    req = 4'b0011;
    step();
    chk_out("wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    ack = 1'b1;
    step();
    ack = 1'b0;

    // timeout: rr_ptr 1, grant requester 1, no ack
    req = 4'b0010;
    step();
    chk_out("to_b0", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      step();
      chk_out($sformatf("to_b%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_out("to_fire", 4'b0000, 2'd1, 1'b0, 1'b1);
    step();
    chk_out("to_pulse", 4'b0000, 2'd1, 1'b0, 1'b0);
    // rr_ptr advanced to 2
    req = 4'b0110;
    step();
    chk_out("to_ptr", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    ack = 1'b1;
    step();
    ack = 1'b0;

    // ack on the 4th busy cycle wins over timeout; rr_ptr 3 wraps to 0
    req = 4'b0001;
    step();
    chk_out("ackto_b0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); step(); step();
    chk_out("ackto_b3", 4'b0001, 2'd0, 1'b1, 1'b0);
    ack = 1'b1;
    step();
    chk_out("ackto_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    ack = 1'b0;
    step();
    chk_out("ackto_after", 4'b0000, 2'd0, 1'b0, 1'b0);

    // reset mid-grant; rr_ptr is 1, only requester 3 asks
    req = 4'b1000;
    step();
    chk_out("rst_busy", 4'b1000, 2'd3, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    chk_out("rst_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("rst_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    ack = 1'b1;
    step();
    chk_out("rst_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
    ack = 1'b0;

    // first grant after reset arbitrates from rr_ptr 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    step();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
